// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to build in the WAIT_DONE watchdog (o_Timeout).
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | no frame owned; arbitrate from ptr when any request is up
// S_ISSUE     | winner registered, one-cycle o_TX_DV strobe to the UART
// S_WAIT_DONE | waiting for i_TX_Done (or watchdog abort)
// S_GAP       | GAP_CLKS idle clocks before the next arbitration

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 0,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [NUM_REQ*8-1:0]   i_Data,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic [NUM_REQ-1:0]     o_Ack,
    output logic                   o_Busy,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Done,
    output logic                   o_Timeout
);

    localparam int          PTR_W    = $clog2(NUM_REQ);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_q;
    logic [15:0]        gap_cnt;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic [NUM_REQ-1:0] win_onehot;
    logic               to_hit;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // First asserted request at or above ptr, wrapping to 0.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_add(ptr, i);
            if (!win_found && i_Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        if (win_found) win_onehot[win_idx] = 1'b1;
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [23:0] TO_LAST = 24'(12 * CLKS_PER_BIT - 1);
    logic [23:0] to_cnt;
    assign to_hit = (to_cnt == TO_LAST);
`else
    // CLKS_PER_BIT only sizes the watchdog, which is not built here.
    logic unused_cfg;
    assign unused_cfg = (CLKS_PER_BIT > 0);
    assign to_hit     = 1'b0;
    assign o_Timeout  = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            win_q     <= '0;
            gap_cnt   <= '0;
            o_Grant   <= '0;
            o_Ack     <= '0;
            o_Busy    <= 1'b0;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            o_Timeout <= 1'b0;
`endif
        end else begin
            o_TX_DV <= 1'b0;
            o_Ack   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            o_Timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state     <= S_ISSUE;
                        win_q     <= win_idx;
                        o_Grant   <= win_onehot;
                        o_TX_Byte <= i_Data[8*int'(win_idx) +: 8];
                        o_TX_DV   <= 1'b1;
                        o_Busy    <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    state <= S_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end

                S_WAIT_DONE: begin
                    if (i_TX_Done || to_hit) begin
                        o_Ack   <= o_Grant;
                        o_Grant <= '0;
                        ptr     <= wrap_add(win_q, 1);
                        gap_cnt <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        o_Timeout <= ~i_TX_Done;
`endif
                        if (GAP_CLKS == 0) begin
                            state  <= S_IDLE;
                            o_Busy <= 1'b0;
                        end else begin
                            state  <= S_GAP;
                        end
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 24'd1;
                    end
`endif
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= S_IDLE;
                        o_Busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance A has no gap, instance B has a 3-clock gap.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int GAP_B = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        done_a, done_b;

    logic [3:0]  grant_a, ack_a, grant_b, ack_b;
    logic        busy_a, dv_a, tmo_a, busy_b, dv_b, tmo_b;
    logic [7:0]  byte_a, byte_b;

    logic [7:0]  byte_tbl [4] = '{8'hC3, 8'h5A, 8'hA5, 8'h3C};

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(0), .CLKS_PER_BIT(4)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req), .i_Data(data),
        .o_Grant(grant_a), .o_Ack(ack_a), .o_Busy(busy_a), .o_TX_DV(dv_a),
        .o_TX_Byte(byte_a), .i_TX_Done(done_a), .o_Timeout(tmo_a)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(GAP_B), .CLKS_PER_BIT(4)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req), .i_Data(data),
        .o_Grant(grant_b), .o_Ack(ack_b), .o_Busy(busy_b), .o_TX_DV(dv_b),
        .o_TX_Byte(byte_b), .i_TX_Done(done_b), .o_Timeout(tmo_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = 4'b0000; done_a = 1'b0; done_b = 1'b0;
        data = {byte_tbl[3], byte_tbl[2], byte_tbl[1], byte_tbl[0]};
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic wait_dv_a(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick;
            if (dv_a) begin found = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b1111; done_a = 1'b1; done_b = 1'b1;
        tick; tick;
        rst = 1'b0; req = 4'b0000; done_a = 1'b0; done_b = 1'b0;
        vec_cnt++; if ({grant_a, ack_a, busy_a, dv_a, byte_a, tmo_a} !== 19'h0) begin
            err_cnt++; $display("FAIL reset_a: got grant=%b ack=%b busy=%b dv=%b byte=%h tmo=%b, want all 0", grant_a, ack_a, busy_a, dv_a, byte_a, tmo_a); end
        vec_cnt++; if ({grant_b, ack_b, busy_b, dv_b, byte_b, tmo_b} !== 19'h0) begin
            err_cnt++; $display("FAIL reset_b: got grant=%b ack=%b busy=%b dv=%b byte=%h tmo=%b, want all 0", grant_b, ack_b, busy_b, dv_b, byte_b, tmo_b); end
    endtask

    task automatic test_single;
        do_reset;
        req = 4'b0100;
        tick;
        vec_cnt++; if (grant_a !== 4'b0100) begin err_cnt++; $display("FAIL single_grant: got %b want 0100", grant_a); end
        vec_cnt++; if (dv_a !== 1'b1) begin err_cnt++; $display("FAIL single_dv_hi: got %b want 1", dv_a); end
        vec_cnt++; if (busy_a !== 1'b1) begin err_cnt++; $display("FAIL single_busy: got %b want 1", busy_a); end
        vec_cnt++; if (byte_a !== 8'hA5) begin err_cnt++; $display("FAIL single_byte: got %h want a5", byte_a); end
        tick;
        vec_cnt++; if (dv_a !== 1'b0) begin err_cnt++; $display("FAIL single_dv_lo: got %b want 0", dv_a); end
        vec_cnt++; if (grant_a !== 4'b0100) begin err_cnt++; $display("FAIL single_grant_held: got %b want 0100", grant_a); end
        tick;
        done_a = 1'b1;
        tick;
        done_a = 1'b0; req = 4'b0000;
        vec_cnt++; if (ack_a !== 4'b0100) begin err_cnt++; $display("FAIL single_ack: got %b want 0100", ack_a); end
        vec_cnt++; if (grant_a !== 4'b0000) begin err_cnt++; $display("FAIL single_grant_clr: got %b want 0000", grant_a); end
        vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL single_idle: got busy=%b want 0", busy_a); end
        tick;
        vec_cnt++; if (ack_a !== 4'b0000) begin err_cnt++; $display("FAIL single_ack_pulse: got %b want 0000", ack_a); end
    endtask

    task automatic test_round_robin;
        bit       found;
        int       exp_i;
        logic [3:0] exp_g;
        do_reset;
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            exp_i = f % 4;
            exp_g = 4'b0001 << exp_i;
            wait_dv_a(4, found);
            vec_cnt++;
            if (!found) begin
                err_cnt++; $display("FAIL rr_dv_timeout: frame %0d got no dv, want dv within 4 clocks", f);
            end else begin
                vec_cnt++; if (grant_a !== exp_g) begin err_cnt++; $display("FAIL rr_grant: frame %0d got %b want %b", f, grant_a, exp_g); end
                vec_cnt++; if (byte_a !== byte_tbl[exp_i]) begin err_cnt++; $display("FAIL rr_byte: frame %0d got %h want %h", f, byte_a, byte_tbl[exp_i]); end
            end
            tick;
            vec_cnt++; if (dv_a !== 1'b0) begin err_cnt++; $display("FAIL rr_dv_one_cycle: frame %0d got %b want 0", f, dv_a); end
            done_a = 1'b1;
            tick;
            done_a = 1'b0;
            vec_cnt++; if (ack_a !== exp_g) begin err_cnt++; $display("FAIL rr_ack: frame %0d got %b want %b", f, ack_a, exp_g); end
        end
        req = 4'b0000;
    endtask

    task automatic test_gap;
        int ka, kb;
        do_reset;
        req = 4'b0001;
        tick;
        vec_cnt++; if (dv_b !== 1'b1) begin err_cnt++; $display("FAIL gap_first_dv: got %b want 1", dv_b); end
        tick; tick;
        done_a = 1'b1; done_b = 1'b1;
        tick;
        done_a = 1'b0; done_b = 1'b0;
        vec_cnt++; if (ack_b !== 4'b0001) begin err_cnt++; $display("FAIL gap_ack: got %b want 0001", ack_b); end
        vec_cnt++; if (busy_b !== 1'b1) begin err_cnt++; $display("FAIL gap_busy: got %b want 1", busy_b); end
        vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL nogap_idle: got busy=%b want 0", busy_a); end
        ka = 0; kb = 0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (dv_a && ka == 0) ka = k;
            if (dv_b && kb == 0) kb = k;
        end
        vec_cnt++; if (ka !== 1) begin err_cnt++; $display("FAIL nogap_latency: got %0d clocks want 1", ka); end
        vec_cnt++; if (kb !== GAP_B + 1) begin err_cnt++; $display("FAIL gap_latency: got %0d clocks want %0d", kb, GAP_B + 1); end
        req = 4'b0000;
    endtask

    task automatic test_spurious_done;
        do_reset;
        done_a = 1'b1;
        tick;
        done_a = 1'b0;
        vec_cnt++; if (ack_a !== 4'b0000) begin err_cnt++; $display("FAIL spur_ack: got %b want 0000", ack_a); end
        vec_cnt++; if (busy_a !== 1'b0) begin err_cnt++; $display("FAIL spur_busy: got %b want 0", busy_a); end
        tick;
        vec_cnt++; if ({grant_a, dv_a} !== 5'b0) begin err_cnt++; $display("FAIL spur_idle: got grant=%b dv=%b want 0", grant_a, dv_a); end
        req = 4'b0010;
        tick;
        vec_cnt++; if (grant_a !== 4'b0010) begin err_cnt++; $display("FAIL spur_then_grant: got %b want 0010", grant_a); end
        req = 4'b0000;
    endtask

    task automatic test_midframe_reset;
        do_reset;
        req = 4'b0001;
        tick; tick;
        done_a = 1'b1;
        tick;
        done_a = 1'b0; req = 4'b0011;
        tick;
        vec_cnt++; if (grant_a !== 4'b0010) begin err_cnt++; $display("FAIL ptr_rotated: got %b want 0010", grant_a); end
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0; req = 4'b0000; done_a = 1'b1;
        vec_cnt++; if ({grant_a, ack_a, busy_a, dv_a, byte_a, tmo_a} !== 19'h0) begin
            err_cnt++; $display("FAIL midreset_outputs: got grant=%b ack=%b busy=%b dv=%b byte=%h tmo=%b, want all 0", grant_a, ack_a, busy_a, dv_a, byte_a, tmo_a); end
        tick;
        done_a = 1'b0;
        vec_cnt++; if ({ack_a, busy_a} !== 5'b0) begin err_cnt++; $display("FAIL late_done: got ack=%b busy=%b want 0", ack_a, busy_a); end
        req = 4'b0011;
        tick;
        vec_cnt++; if (grant_a !== 4'b0001) begin err_cnt++; $display("FAIL midreset_ptr: got %b want 0001", grant_a); end
        req = 4'b0000;
    endtask

    task automatic test_hold_inputs;
        do_reset;
        req = 4'b1000;
        tick;
        vec_cnt++; if (byte_a !== 8'h3C) begin err_cnt++; $display("FAIL hold_byte_grant: got %h want 3c", byte_a); end
        req = 4'b0000; data = 32'h0000_0000;
        tick; tick;
        vec_cnt++; if (byte_a !== 8'h3C) begin err_cnt++; $display("FAIL hold_byte_kept: got %h want 3c", byte_a); end
        vec_cnt++; if (grant_a !== 4'b1000) begin err_cnt++; $display("FAIL hold_grant_kept: got %b want 1000", grant_a); end
        done_a = 1'b1;
        tick;
        done_a = 1'b0;
        vec_cnt++; if (ack_a !== 4'b1000) begin err_cnt++; $display("FAIL drop_req_ack: got %b want 1000", ack_a); end
    endtask

    task automatic test_timeout;
`ifdef UART_TX_ARB_TIMEOUT_EN
        int kt;
        logic [3:0] ack_at;
        logic busy_at;
        do_reset;
        req = 4'b0010;
        tick;
        tick;
        kt = 0; ack_at = 4'b0000; busy_at = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick;
            if (tmo_a) begin kt = k; ack_at = ack_a; busy_at = busy_a; break; end
        end
        req = 4'b0000;
        vec_cnt++; if (kt !== 48) begin err_cnt++; $display("FAIL timeout_latency: got %0d clocks want 48", kt); end
        vec_cnt++; if (ack_at !== 4'b0010) begin err_cnt++; $display("FAIL timeout_ack: got %b want 0010", ack_at); end
        vec_cnt++; if (busy_at !== 1'b0) begin err_cnt++; $display("FAIL timeout_idle: got busy=%b want 0", busy_at); end
        tick;
        vec_cnt++; if (tmo_a !== 1'b0) begin err_cnt++; $display("FAIL timeout_pulse: got %b want 0", tmo_a); end
`else
        bit ack_seen, tmo_seen;
        do_reset;
        req = 4'b0010;
        tick; tick;
        ack_seen = 1'b0; tmo_seen = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            tick;
            if (ack_a !== 4'b0000) ack_seen = 1'b1;
            if (tmo_a !== 1'b0) tmo_seen = 1'b1;
        end
        vec_cnt++; if (busy_a !== 1'b1) begin err_cnt++; $display("FAIL no_wd_busy: got %b want 1", busy_a); end
        vec_cnt++; if (grant_a !== 4'b0010) begin err_cnt++; $display("FAIL no_wd_grant: got %b want 0010", grant_a); end
        vec_cnt++; if ({ack_seen, tmo_seen} !== 2'b00) begin err_cnt++; $display("FAIL no_wd_pulses: got ack_seen=%b tmo_seen=%b want 0", ack_seen, tmo_seen); end
        done_a = 1'b1;
        tick;
        done_a = 1'b0; req = 4'b0000;
        vec_cnt++; if (ack_a !== 4'b0010) begin err_cnt++; $display("FAIL no_wd_late_ack: got %b want 0010", ack_a); end
`endif
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_gap;
        test_spurious_done;
        test_midframe_reset;
        test_hold_inputs;
        test_timeout;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got no end of test, want finish before 1 ms");
        $fatal(1, "time limit");
    end

endmodule
